// File: rtl/memory_sync_if.sv
// Bus bundle for the memory_sync wait-state memory: a level-held EN request
// answered by a registered MFC completion with read data and an error flag.
interface memory_sync_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
);
  logic              EN;
  logic              RW;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] Data_in;
  logic [DATA_W-1:0] Data_out;
  logic              MFC;
  logic              ERR;

  modport master (
    output EN, RW, addr, Data_in,
    input  Data_out, MFC, ERR
  );

  modport slave (
    input  EN, RW, addr, Data_in,
    output Data_out, MFC, ERR
  );
endinterface

// File: rtl/memory_sync.sv
// Single-port word memory with a programmable number of wait states before MFC,
// a read-only zero region at the bottom and an error flag for illegal accesses.
module memory_sync #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned WAIT     = 2,
  parameter int unsigned RO_WORDS = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  memory_sync_if.slave bus
);
  localparam int unsigned     IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] RO_L    = (ADDR_W+1)'(RO_WORDS);
  localparam logic [3:0]      WAIT_L  = 4'(WAIT);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_rw;
  logic              r_ro;
  logic              r_oor;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_din;
  logic [DATA_W-1:0] r_rd_word;
  logic [DATA_W-1:0] r_dout;
  logic              r_mfc;
  logic              r_err;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_cap;
  logic              w_complete;
  logic              w_commit;
  logic [IDX_W-1:0]  w_idx_in;

  assign w_cap      = (r_state == IDLE) && bus.EN;
  assign w_complete = (r_state == ACCESS) && bus.EN && (r_cnt == 4'd0);
  assign w_commit   = w_complete && !r_rw && !r_ro && !r_oor;
  assign w_idx_in   = bus.addr[IDX_W-1:0];

  // Array read is taken at the capture edge so the DONE edge only moves a
  // register; no write can land in between because the FSM is single-issue.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_mem[r_idx] <= r_din;
    end
    if (w_cap) begin
      r_rd_word <= r_mem[w_idx_in];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_rw    <= 1'b1;
      r_ro    <= 1'b0;
      r_oor   <= 1'b0;
      r_idx   <= '0;
      r_din   <= '0;
      r_dout  <= '0;
      r_mfc   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.EN) begin
            r_state <= ACCESS;
            r_cnt   <= WAIT_L;
            r_rw    <= bus.RW;
            r_idx   <= w_idx_in;
            r_din   <= bus.Data_in;
            // Range flags use the full address so out-of-range words never alias.
            r_ro    <= ({1'b0, bus.addr} < RO_L);
            r_oor   <= !({1'b0, bus.addr} < DEPTH_L);
          end
        end
        ACCESS: begin
          if (!bus.EN) begin
            r_state <= IDLE;
          end else if (r_cnt == 4'd0) begin
            r_state <= DONE;
            r_mfc   <= 1'b1;
            if (r_rw) begin
              r_dout <= (r_ro || r_oor) ? '0 : r_rd_word;
              r_err  <= r_oor;
            end else begin
              r_err  <= r_ro || r_oor;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        DONE: begin
          if (!bus.EN) begin
            r_state <= IDLE;
            r_mfc   <= 1'b0;
            r_err   <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.Data_out = r_dout;
  assign bus.MFC      = r_mfc;
  assign bus.ERR      = r_err;
endmodule

// File: tb/tb_memory_sync.sv
// Scoreboard bench for memory_sync: one WAIT=2 instance and one WAIT=0 instance,
// directed accesses push expectations, per-instance monitors pop on MFC rise.
module tb_memory_sync;
  logic clk = 1'b0;
  logic rst_n_a = 1'b0;
  logic rst_n_b = 1'b0;
  int   cyc = 0;
  int   nvec = 0;
  int   nfail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  memory_sync_if #(.DATA_W(16), .ADDR_W(16)) bus_a ();
  memory_sync_if #(.DATA_W(16), .ADDR_W(16)) bus_b ();

  memory_sync #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT(2), .RO_WORDS(8)) u_dut_a (
    .clk     (clk),
    .reset_n (rst_n_a),
    .bus     (bus_a)
  );

  memory_sync #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT(0), .RO_WORDS(8)) u_dut_b (
    .clk     (clk),
    .reset_n (rst_n_b),
    .bus     (bus_b)
  );

  typedef struct {
    logic        rd;
    logic [15:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  logic prev_a = 1'b0;
  logic prev_b = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    nvec++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic drive(input bit sel, input logic en, input logic rw,
                       input logic [15:0] a, input logic [15:0] d);
    if (sel) begin
      bus_b.EN = en; bus_b.RW = rw; bus_b.addr = a; bus_b.Data_in = d;
    end else begin
      bus_a.EN = en; bus_a.RW = rw; bus_a.addr = a; bus_a.Data_in = d;
    end
  endtask

  function automatic logic mfc_of(input bit sel);
    return sel ? bus_b.MFC : bus_a.MFC;
  endfunction

  task automatic check_pop(input bit sel);
    exp_t        e;
    logic [15:0] d;
    logic        er;
    d  = sel ? bus_b.Data_out : bus_a.Data_out;
    er = sel ? bus_b.ERR : bus_a.ERR;
    if (sel ? (q_b.size() == 0) : (q_a.size() == 0)) begin
      nvec++;
      nfail++;
      $display("FAIL unexpected_mfc dut=%0d actual=MFC_high required=no_access_pending", sel);
      return;
    end
    if (sel) e = q_b.pop_front();
    else     e = q_a.pop_front();
    chk($sformatf("latency_dut%0d", sel), 16'(cyc), 16'(e.due));
    chk($sformatf("err_dut%0d", sel), {15'd0, er}, {15'd0, e.err});
    chk($sformatf("%s_data_dut%0d", e.rd ? "rd" : "wr", sel), d, e.data);
  endtask

  always @(negedge clk) begin
    if (bus_a.MFC && !prev_a) check_pop(1'b0);
    prev_a <= bus_a.MFC;
  end

  always @(negedge clk) begin
    if (bus_b.MFC && !prev_b) check_pop(1'b1);
    prev_b <= bus_b.MFC;
  end

  // One complete access; capture-time inputs are scrambled right after capture.
  task automatic access(input bit sel, input logic rw, input logic [15:0] a,
                        input logic [15:0] din, input logic [15:0] exp_d,
                        input logic exp_e, input int hold);
    int   t0;
    bit   seen;
    exp_t e;
    @(negedge clk);
    drive(sel, 1'b1, rw, a, din);
    @(posedge clk);
    #1;
    t0     = cyc;
    e.rd   = rw;
    e.data = exp_d;
    e.err  = exp_e;
    e.due  = t0 + (sel ? 0 : 2) + 1;
    if (sel) q_b.push_back(e);
    else     q_a.push_back(e);
    $display("dut=%0d %s addr=%h din=%h exp_data=%h exp_err=%0d",
             sel, rw ? "RD" : "WR", a, din, exp_d, exp_e);
    @(negedge clk);
    drive(sel, 1'b1, ~rw, ~a, ~din);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (mfc_of(sel)) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    nvec++;
    if (!seen) begin
      nfail++;
      $display("FAIL mfc_timeout dut=%0d actual=MFC_low required=MFC_high", sel);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk($sformatf("mfc_hold%0d_dut%0d", i, sel), {15'd0, mfc_of(sel)}, 16'd1);
    end
    drive(sel, 1'b0, ~rw, ~a, ~din);
    @(negedge clk);
    chk($sformatf("mfc_clear_dut%0d", sel), {15'd0, mfc_of(sel)}, 16'd0);
    chk($sformatf("err_clear_dut%0d", sel), {15'd0, sel ? bus_b.ERR : bus_a.ERR}, 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    drive(1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b1, 16'h0, 16'h0);
    repeat (3) @(negedge clk);
    chk("rst_dout_a", bus_a.Data_out, 16'h0000);
    chk("rst_mfc_a", {15'd0, bus_a.MFC}, 16'd0);
    chk("rst_err_a", {15'd0, bus_a.ERR}, 16'd0);
    chk("rst_dout_b", bus_b.Data_out, 16'h0000);
    chk("rst_mfc_b", {15'd0, bus_b.MFC}, 16'd0);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;

    access(0, 0, 16'h0010, 16'h1234, 16'h0000, 0, 0);
    access(0, 1, 16'h0010, 16'h0000, 16'h1234, 0, 0);
    access(0, 0, 16'h0003, 16'hFFFF, 16'h1234, 1, 0);
    access(0, 1, 16'h0003, 16'h0000, 16'h0000, 0, 0);
    access(0, 1, 16'h0100, 16'h0000, 16'h0000, 1, 0);
    access(0, 0, 16'h0100, 16'h5A5A, 16'h0000, 1, 0);
    access(0, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    access(0, 0, 16'h0110, 16'hDEAD, 16'h0000, 1, 0);
    access(0, 1, 16'h0010, 16'h0000, 16'h1234, 0, 0);
    access(0, 0, 16'h0008, 16'h0808, 16'h1234, 0, 0);
    access(0, 1, 16'h0008, 16'h0000, 16'h0808, 0, 0);
    access(0, 0, 16'h0007, 16'h7777, 16'h0808, 1, 0);
    access(0, 1, 16'h0007, 16'h0000, 16'h0000, 0, 0);
    access(0, 0, 16'h00FF, 16'h0BEE, 16'h0000, 0, 0);
    access(0, 1, 16'h00FF, 16'h0000, 16'h0BEE, 0, 0);
    access(0, 1, 16'hFFFF, 16'h0000, 16'h0000, 1, 0);
    access(0, 0, 16'h0020, 16'h1111, 16'h0000, 0, 0);

    // Aborted write: EN drops after one edge spent in ACCESS.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 16'h0020, 16'hABCD);
    $display("dut=0 WR addr=0020 din=abcd aborted");
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 16'h0077, 16'h0000);
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 16'h0077, 16'h0000);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus_a.MFC) seen = 1;
    end
    chk("abort_mfc", {15'd0, seen}, 16'd0);
    access(0, 1, 16'h0020, 16'h0000, 16'h1111, 0, 0);

    access(0, 0, 16'h0030, 16'h2222, 16'h1111, 0, 0);
    access(0, 1, 16'h0030, 16'h0000, 16'h2222, 0, 0);

    // Reset mid-ACCESS of a write; outputs must clear before any clock edge.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 16'h0030, 16'h5555);
    $display("dut=0 WR addr=0030 din=5555 reset mid-access");
    @(posedge clk);
    @(negedge clk);
    #2;
    rst_n_a = 1'b0;
    #1;
    chk("rst_async_dout", bus_a.Data_out, 16'h0000);
    chk("rst_async_mfc", {15'd0, bus_a.MFC}, 16'd0);
    chk("rst_async_err", {15'd0, bus_a.ERR}, 16'd0);
    drive(0, 1'b0, 1'b1, 16'h0000, 16'h0000);
    @(negedge clk);
    rst_n_a = 1'b1;
    access(0, 1, 16'h0030, 16'h0000, 16'h2222, 0, 0);

    access(1, 0, 16'h0040, 16'h00AA, 16'h0000, 0, 0);
    access(1, 1, 16'h0040, 16'h0000, 16'h00AA, 0, 5);
    access(1, 1, 16'h0005, 16'h0000, 16'h0000, 0, 0);
    access(1, 0, 16'h0005, 16'h0001, 16'h0000, 1, 0);

    repeat (3) @(negedge clk);
    chk("queue_a_empty", 16'(q_a.size()), 16'd0);
    chk("queue_b_empty", 16'(q_b.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
